timer_ctrl: RTL



---
 rtl/timer_pkg.sv | 34 +++
 rtl/tick_prescaler.sv | 30 +++
 rtl/timer_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state codes, BCD digit constants
// and the strobe arbitration used when several control strobes coincide.
package timer_pkg;

  localparam int               BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Encoded value doubles as priority: a larger code beats a smaller one.
  typedef enum logic [2:0] {
    SB_NONE  = 3'd0,
    SB_KEY   = 3'd1,
    SB_START = 3'd2,
    SB_STOP  = 3'd3,
    SB_CLEAR = 3'd4
  } strobe_e;

  function automatic strobe_e pick_strobe(input logic i_clear, input logic i_stop,
                                          input logic i_start, input logic i_key);
    if (i_clear)      return SB_CLEAR;
    else if (i_stop)  return SB_STOP;
    else if (i_start) return SB_START;
    else if (i_key)   return SB_KEY;
    return SB_NONE;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV counter; o_tick is high combinationally while the count sits at TICK_DIV-1.
// i_clr forces zero (wins over i_hold); i_hold freezes the count.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_tick
);

  localparam int            CW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] W_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= (r_cnt == W_MAX) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == W_MAX);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: keypad entry, load of the BCD down-counter chain, one count strobe per tick.
// Define TIMER_AUTO_RELOAD_EN for a periodic timer that reloads and restarts after a one-cycle DONE.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int DIGITS   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [BCD_W-1:0]          key_digit,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      cnt_zero,
  output logic                      load,
  output logic [BCD_W*DIGITS-1:0]   load_data,
  output logic                      enablen,
  output logic                      done,
  output logic [2:0]                state
);

  localparam int LW = BCD_W * DIGITS;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [LW-1:0] r_load_data;
  logic [LW-1:0] w_load_data_nxt;
  logic          r_load;
  logic          w_load_nxt;
  logic          w_ps_clr;
  logic          w_ps_hold;
  logic          w_tick;
  logic          w_key_ok;
  strobe_e       w_strobe;
  logic [LW-1:0] w_shift;
  logic [LW-1:0] w_fresh;

  assign w_key_ok = key_valid && (key_digit <= BCD_MAX);
  assign w_strobe = pick_strobe(clear, stop, start, w_key_ok);
  assign w_shift  = {r_load_data[LW-BCD_W-1:0], key_digit};
  assign w_fresh  = LW'(key_digit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_load_data <= '0;
      r_load      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_data <= w_load_data_nxt;
      r_load      <= w_load_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_data_nxt = r_load_data;
    w_load_nxt      = 1'b0;
    w_ps_clr        = 1'b0;
    if (w_strobe == SB_CLEAR) begin
      // Abort from anywhere: zero the entry and push zeros into the chain.
      w_state_nxt     = ST_IDLE;
      w_load_data_nxt = '0;
      w_load_nxt      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strobe == SB_KEY) begin
            w_state_nxt     = ST_SET;
            w_load_data_nxt = w_fresh;
          end
        end
        ST_SET: begin
          if (w_strobe == SB_START && r_load_data != '0) begin
            w_state_nxt = ST_RUN;
            w_load_nxt  = 1'b1;
            w_ps_clr    = 1'b1;
          end else if (w_strobe == SB_KEY) begin
            w_load_data_nxt = w_shift;
          end
        end
        ST_RUN: begin
          // cnt_zero still reflects the old chain contents during the load cycle.
          if (cnt_zero && !r_load) begin
            w_state_nxt = ST_DONE;
          end else if (w_strobe == SB_STOP) begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (w_strobe == SB_START) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (w_strobe == SB_START) begin
            w_state_nxt = ST_IDLE;
          end else if (w_strobe == SB_KEY) begin
            w_state_nxt     = ST_SET;
            w_load_data_nxt = w_fresh;
          end else begin
`ifdef TIMER_AUTO_RELOAD_EN
            w_state_nxt = ST_RUN;
            w_load_nxt  = 1'b1;
            w_ps_clr    = 1'b1;
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Count only in settled RUN cycles that stay in RUN, so a tick that meets stop/clear/zero is deferred or dropped.
  assign w_ps_hold = (r_state != ST_RUN) || r_load || (w_state_nxt != ST_RUN);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_ps_clr),
    .i_hold (w_ps_hold),
    .o_tick (w_tick)
  );

  assign enablen   = !((r_state == ST_RUN) && (w_state_nxt == ST_RUN) && !r_load && w_tick);
  assign load      = r_load;
  assign load_data = r_load_data;
  assign done      = (r_state == ST_DONE);
  assign state     = r_state;

endmodule
